// File: rtl/router_pkg.sv
// Shared types and constants for the router front-end blocks.
package router_pkg;

    localparam int DATA_WIDTH_DEF = 32;
    localparam int ADDR_WIDTH_DEF = 2;
    localparam int PKT_CNT_W      = 16;

    typedef enum logic [0:0] {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Rotating priority encoder: first set bit of valid, searching upward from ptr
// with wrap-around; returns a one-hot grant, its index and an any-valid flag.
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  valid,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          any
);

    logic [IW-1:0] pos_s;

    // Walk the N candidate positions in priority order and keep the first hit.
    always_comb begin
        grant = {N{1'b0}};
        idx   = {IW{1'b0}};
        any   = 1'b0;
        pos_s = {IW{1'b0}};
        for (int k = 0; k < N; k++) begin
            pos_s = IW'((int'(ptr) + k) % N);
            if (!any && valid[pos_s]) begin
                any          = 1'b1;
                grant[pos_s] = 1'b1;
                idx          = pos_s;
            end else begin
                any = any;
            end
        end
    end

endmodule

// File: rtl/router_arbiter.sv
// Round-robin, packet-locking arbiter that registers the winning beat onto the
// router input bus. Define ROUTER_ARB_STATS_EN to add per-requester packet counters.
module router_arbiter
    import router_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int NUM_REQ    = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_last,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [DATA_WIDTH-1:0]         data_in,
    output logic                          data_en,
    output logic [ADDR_WIDTH-1:0]         addr,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id
`ifdef ROUTER_ARB_STATS_EN
    ,
    output logic [NUM_REQ*PKT_CNT_W-1:0]  pkt_cnt
`endif
);

    localparam int IDX_W = $clog2(NUM_REQ);

    arb_state_e              state_r;
    logic [IDX_W-1:0]        ptr_r;
    logic [IDX_W-1:0]        owner_r;
    logic [ADDR_WIDTH-1:0]   dest_r;

    logic [NUM_REQ-1:0]      pick_grant_s;
    logic [IDX_W-1:0]        pick_idx_s;
    logic                    pick_any_s;

    logic [NUM_REQ-1:0]      ready_s;
    logic                    accept_s;
    logic [IDX_W-1:0]        sel_idx_s;
    logic                    sel_last_s;
    logic [DATA_WIDTH-1:0]   sel_data_s;
    logic [ADDR_WIDTH-1:0]   sel_addr_s;
    logic [IDX_W-1:0]        next_ptr_s;

    rr_pick #(
        .N  (NUM_REQ),
        .IW (IDX_W)
    ) u_rr_pick (
        .valid (req_valid),
        .ptr   (ptr_r),
        .grant (pick_grant_s),
        .idx   (pick_idx_s),
        .any   (pick_any_s)
    );

    // Ready vector and selected beat; nothing is accepted while reset is applied.
    always_comb begin
        ready_s    = {NUM_REQ{1'b0}};
        sel_idx_s  = {IDX_W{1'b0}};
        sel_addr_s = {ADDR_WIDTH{1'b0}};
        case (state_r)
            ARB_IDLE: begin
                sel_idx_s  = pick_idx_s;
                sel_addr_s = req_addr[int'(pick_idx_s)*ADDR_WIDTH +: ADDR_WIDTH];
                if (pick_any_s) begin
                    ready_s = pick_grant_s;
                end else begin
                    ready_s = {NUM_REQ{1'b0}};
                end
            end
            ARB_LOCKED: begin
                sel_idx_s          = owner_r;
                sel_addr_s         = dest_r;
                ready_s[owner_r]   = req_valid[owner_r];
            end
            default: begin
                ready_s = {NUM_REQ{1'b0}};
            end
        endcase
        if (rst) begin
            ready_s = {NUM_REQ{1'b0}};
        end else begin
            ready_s = ready_s;
        end
        accept_s   = |ready_s;
        sel_last_s = req_last[sel_idx_s];
        sel_data_s = req_data[int'(sel_idx_s)*DATA_WIDTH +: DATA_WIDTH];
        if (sel_idx_s == IDX_W'(NUM_REQ - 1)) begin
            next_ptr_s = {IDX_W{1'b0}};
        end else begin
            next_ptr_s = sel_idx_s + IDX_W'(1);
        end
    end

    assign req_ready = ready_s;

    // Arbitration state and the registered router-side beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= ARB_IDLE;
            ptr_r    <= {IDX_W{1'b0}};
            owner_r  <= {IDX_W{1'b0}};
            dest_r   <= {ADDR_WIDTH{1'b0}};
            data_in  <= {DATA_WIDTH{1'b0}};
            data_en  <= 1'b0;
            addr     <= {ADDR_WIDTH{1'b0}};
            grant_id <= {IDX_W{1'b0}};
        end else begin
            data_en <= accept_s;
            if (accept_s) begin
                data_in  <= sel_data_s;
                addr     <= sel_addr_s;
                grant_id <= sel_idx_s;
                owner_r  <= sel_idx_s;
                dest_r   <= sel_addr_s;
                if (sel_last_s) begin
                    state_r <= ARB_IDLE;
                    ptr_r   <= next_ptr_s;
                end else begin
                    state_r <= ARB_LOCKED;
                end
            end else begin
                state_r <= state_r;
            end
        end
    end

`ifdef ROUTER_ARB_STATS_EN
    // Saturating per-requester count of completed packets.
    always_ff @(posedge clk) begin
        if (rst) begin
            pkt_cnt <= {(NUM_REQ*PKT_CNT_W){1'b0}};
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (accept_s && sel_last_s && (sel_idx_s == IDX_W'(i)) &&
                    (pkt_cnt[i*PKT_CNT_W +: PKT_CNT_W] != {PKT_CNT_W{1'b1}})) begin
                    pkt_cnt[i*PKT_CNT_W +: PKT_CNT_W] <=
                        pkt_cnt[i*PKT_CNT_W +: PKT_CNT_W] + PKT_CNT_W'(1);
                end else begin
                    pkt_cnt[i*PKT_CNT_W +: PKT_CNT_W] <= pkt_cnt[i*PKT_CNT_W +: PKT_CNT_W];
                end
            end
        end
    end
`else
    // Statistics counters are not built in this configuration.
`endif

endmodule
